branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Direction predictor that generates `id_br_pred`, which the hazard controller consumes to decide bubbles, and learns from the branch outcome resolved in EX.
- Table of 2-bit saturating counters (BHT), indexed by PC, optionally XOR-hashed with a global history register (gshare).
- Lookup is combinational in ID. Training happens at the clock edge when the EX-stage branch resolves.
- The lookup index is exported so the pipeline can carry it to EX and train the exact entry that was read.

Parameters:
- PC_WIDTH, 64, width of PC inputs.
- INDEX_BITS, 6, log2 of BHT entries (64 entries).
- HIST_BITS, 4, global history length. 0 = pure bimodal. Legal range 0..INDEX_BITS.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- id_pc  in  PC_WIDTH  PC of the instruction in ID
- id_is_branch  in  1  ID instruction is a conditional branch
- id_br_pred  out  1  predicted taken; 0 when id_is_branch=0
- id_pred_index  out  INDEX_BITS  BHT index used for this lookup, carried down the pipeline to EX
- ex_update_en  in  1  one-cycle strobe: EX branch resolved; integrator asserts exactly once per branch (gated by !pc_stall)
- ex_pred_index  in  INDEX_BITS  index carried from ID with the branch
- ex_br_taken  in  1  resolved direction (controller br_taken)
- ex_br_pred  in  1  prediction carried with the branch
- ghr  out  HIST_BITS (min 1)  current global history; reads 0 when HIST_BITS=0
- stat_branches  out  32  resolved-branch count
- stat_mispred  out  32  misprediction count

Behaviour:
- Counter encoding:
  - 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
  - Predict taken = counter bit 1.
- Index: idx = id_pc[INDEX_BITS+1:2] XOR {zero-extended ghr}. The history occupies the low HIST_BITS bits of the index.
- Lookup:
  - Combinational, zero-cycle latency.
  - id_br_pred = id_is_branch AND bht[idx][1].
  - id_pred_index = idx regardless of id_is_branch.
- Update (rising clk, ex_update_en=1):
  - taken: bht[ex_pred_index] = min(cnt+1, 3).
  - not taken: bht[ex_pred_index] = max(cnt-1, 0).
  - ghr shifts left by 1 with ex_br_taken inserted at bit 0; the oldest bit is dropped.
  - stat_branches += 1.
  - stat_mispred += 1 if ex_br_taken != ex_br_pred.
  - Both stat counters wrap modulo 2^32.
- ex_update_en=0: no state changes. The values of ex_pred_index, ex_br_taken and ex_br_pred are ignored.
- History is non-speculative: it changes only on resolution, never on prediction.
- Same-cycle lookup and update:
  - Lookup sees pre-edge state, i.e. the old counter and the old ghr (read-before-write).
  - The new value is visible the cycle after the edge.
- Held stage: while ID is held by a stall, lookup output simply tracks the current table. No internal state advances.
- Reset (asynchronous, any time, including mid-update):
  - All BHT entries = 01.
  - ghr = 0, stat_branches = 0, stat_mispred = 0.
  - Outputs reflect reset state immediately.
  - An update strobe coincident with reset is discarded.
- HIST_BITS=0:
  - No history register is generated.
  - idx = PC bits only.
  - ghr port is tied 0.
- PC bits [1:0] and bits above INDEX_BITS+1 do not affect the index; aliasing is accepted.
- No X propagation: id_br_pred is defined for any id_pc value.

Test Plan:
- Reset then lookup: id_pc=0x40, id_is_branch=1 -> id_br_pred=0, id_pred_index=0x10, ghr=0, both stats 0.
- Training to taken (HIST_BITS=0):
  - Two taken updates at index 0x10 with ex_br_pred=0 -> counter 01→10→11.
  - Lookup at 0x40 then predicts 1; stat_branches=2, stat_mispred=2.
  - Two more taken updates -> counter saturates at 11; stat_mispred unchanged when ex_br_pred=1.
- Saturate low, then hysteresis (HIST_BITS=0):
  - Three not-taken updates at index 5 -> counter 00, prediction 0.
  - One taken -> 01, still predicts 0.
  - A second taken -> 10, predicts 1.
- Same-cycle hazard:
  - Entry 0x10 = 01. In the same cycle, taken update at 0x10 and ID lookup of id_pc=0x40.
  - id_br_pred=0 before the edge, 1 after.
- gshare (HIST_BITS=4):
  - Resolve taken, taken, not-taken, taken -> ghr=4'b1101.
  - Lookup id_pc=0x40 -> id_pred_index = 0x10 XOR 0x0D = 0x1D.
- Reset mid-stream and wrap:
  - Assert rst asynchronously between edges during an update burst -> all state cleared at once; the coincident strobe is ignored.
  - Force stat_branches to 0xFFFFFFFF via 2^32-1 updates, or a bench backdoor, then one more update -> 0x00000000.

Source files
------------

// File: rtl/branch_predictor.sv
// Direction predictor: table of 2-bit saturating counters indexed by PC, optionally hashed with a
// non-speculative global history (gshare). Combinational lookup in ID, training on EX resolution.
module branch_predictor #(
  parameter int unsigned PC_WIDTH   = 64,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned HIST_BITS  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [PC_WIDTH-1:0]                         id_pc,
  input  logic                                        id_is_branch,
  output logic                                        id_br_pred,
  output logic [INDEX_BITS-1:0]                       id_pred_index,
  input  logic                                        ex_update_en,
  input  logic [INDEX_BITS-1:0]                       ex_pred_index,
  input  logic                                        ex_br_taken,
  input  logic                                        ex_br_pred,
  output logic [((HIST_BITS > 0) ? HIST_BITS : 1)-1:0] ghr,
  output logic [31:0]                                 stat_branches,
  output logic [31:0]                                 stat_mispred
);

  localparam int unsigned NumEntries = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    CntStrongNt = 2'b00,
    CntWeakNt   = 2'b01,
    CntWeakT    = 2'b10,
    CntStrongT  = 2'b11
  } cnt_e;

  logic [1:0]            bht_q [NumEntries];
  logic [1:0]            upd_cnt;
  logic [1:0]            upd_cnt_d;
  logic [INDEX_BITS-1:0] hist_idx;
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [31:0]           stat_branches_q, stat_branches_d;
  logic [31:0]           stat_mispred_q, stat_mispred_d;

  // PC byte-offset bits and bits above the index are deliberately ignored (aliasing accepted).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{id_pc[PC_WIDTH-1:INDEX_BITS+2], id_pc[1:0]};

  // Global history register, present only in gshare configurations.
  if (HIST_BITS > 0) begin : g_hist
    logic [HIST_BITS-1:0] ghr_q, ghr_d;

    always_comb begin
      ghr_d = ghr_q;
      if (ex_update_en) begin
        ghr_d = HIST_BITS'({ghr_q, ex_br_taken});
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ghr_q <= '0;
      end else begin
        ghr_q <= ghr_d;
      end
    end

    always_comb begin
      hist_idx                = '0;
      hist_idx[HIST_BITS-1:0] = ghr_q;
    end

    assign ghr = ghr_q;
  end else begin : g_no_hist
    assign hist_idx = '0;
    assign ghr      = 1'b0;
  end

  // Lookup reads pre-edge state, so a same-cycle update becomes visible only after the edge.
  assign lookup_idx    = id_pc[INDEX_BITS+1:2] ^ hist_idx;
  assign id_pred_index = lookup_idx;
  assign id_br_pred    = id_is_branch & bht_q[lookup_idx][1];

  assign upd_cnt = bht_q[ex_pred_index];

  always_comb begin
    upd_cnt_d = upd_cnt;
    if (ex_br_taken) begin
      if (upd_cnt != CntStrongT) begin
        upd_cnt_d = upd_cnt + 2'd1;
      end
    end else begin
      if (upd_cnt != CntStrongNt) begin
        upd_cnt_d = upd_cnt - 2'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumEntries; i++) begin
        bht_q[i] <= CntWeakNt;
      end
    end else if (ex_update_en) begin
      bht_q[ex_pred_index] <= upd_cnt_d;
    end
  end

  // Statistics counters wrap naturally at 2^32.
  always_comb begin
    stat_branches_d = stat_branches_q;
    stat_mispred_d  = stat_mispred_q;
    if (ex_update_en) begin
      stat_branches_d = stat_branches_q + 32'd1;
      if (ex_br_taken != ex_br_pred) begin
        stat_mispred_d = stat_mispred_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_d;
      stat_mispred_q  <= stat_mispred_d;
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench: a bimodal instance (HIST_BITS=0) and a gshare instance (HIST_BITS=4) share stimulus.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] id_pc;
  logic        id_is_branch;
  logic        ex_update_en;
  logic [5:0]  ex_pred_index;
  logic        ex_br_taken;
  logic        ex_br_pred;

  logic        pred_b, pred_g;
  logic [5:0]  idx_b, idx_g;
  logic        ghr_b;
  logic [3:0]  ghr_g;
  logic [31:0] sb_b, sm_b, sb_g, sm_g;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.PC_WIDTH(64), .INDEX_BITS(6), .HIST_BITS(0)) dut_b (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_is_branch(id_is_branch), .id_br_pred(pred_b),
    .id_pred_index(idx_b), .ex_update_en(ex_update_en), .ex_pred_index(ex_pred_index),
    .ex_br_taken(ex_br_taken), .ex_br_pred(ex_br_pred), .ghr(ghr_b), .stat_branches(sb_b),
    .stat_mispred(sm_b)
  );

  branch_predictor #(.PC_WIDTH(64), .INDEX_BITS(6), .HIST_BITS(4)) dut_g (
    .clk(clk), .rst(rst), .id_pc(id_pc), .id_is_branch(id_is_branch), .id_br_pred(pred_g),
    .id_pred_index(idx_g), .ex_update_en(ex_update_en), .ex_pred_index(ex_pred_index),
    .ex_br_taken(ex_br_taken), .ex_br_pred(ex_br_pred), .ghr(ghr_g), .stat_branches(sb_g),
    .stat_mispred(sm_g)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called just after a rising edge; leaves the bench just after the next rising edge.
  task automatic update(input logic [5:0] idx, input logic taken, input logic pred);
    ex_pred_index = idx;
    ex_br_taken   = taken;
    ex_br_pred    = pred;
    ex_update_en  = 1'b1;
    @(posedge clk);
    #1;
    ex_update_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; id_pc = 64'h40; id_is_branch = 1'b1;
    ex_update_en = 1'b0; ex_pred_index = '0; ex_br_taken = 1'b0; ex_br_pred = 1'b0;
    #2;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL rst_pred: got %b want 0", pred_b); else n_pass++;
    @(posedge clk); #1; rst = 1'b0; #1;
    n_checks++; if (idx_b !== 6'h10) $display("FAIL rst_idx_b: got %h want 10", idx_b); else n_pass++;
    n_checks++; if (idx_g !== 6'h10) $display("FAIL rst_idx_g: got %h want 10", idx_g); else n_pass++;
    n_checks++; if (ghr_g !== 4'h0) $display("FAIL rst_ghr: got %h want 0", ghr_g); else n_pass++;
    n_checks++;
    if (sb_b !== 32'd0 || sm_b !== 32'd0) $display("FAIL rst_stats: got %0d/%0d want 0/0", sb_b, sm_b);
    else n_pass++;
  endtask

  task automatic test_train_taken();
    id_pc = 64'h40; id_is_branch = 1'b1;
    update(6'h10, 1'b1, 1'b0);
    n_checks++; if (pred_b !== 1'b1) $display("FAIL tt_weak: got %b want 1", pred_b); else n_pass++;
    update(6'h10, 1'b1, 1'b0);
    n_checks++; if (pred_b !== 1'b1) $display("FAIL tt_strong: got %b want 1", pred_b); else n_pass++;
    n_checks++; if (sb_b !== 32'd2) $display("FAIL tt_br2: got %0d want 2", sb_b); else n_pass++;
    n_checks++; if (sm_b !== 32'd2) $display("FAIL tt_mis2: got %0d want 2", sm_b); else n_pass++;
    id_is_branch = 1'b0; #1;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL tt_notbr: got %b want 0", pred_b); else n_pass++;
    n_checks++; if (idx_b !== 6'h10) $display("FAIL tt_notbr_idx: got %h want 10", idx_b); else n_pass++;
    id_is_branch = 1'b1;
    update(6'h10, 1'b1, 1'b1);
    update(6'h10, 1'b1, 1'b1);
    n_checks++; if (sb_b !== 32'd4) $display("FAIL tt_br4: got %0d want 4", sb_b); else n_pass++;
    n_checks++; if (sm_b !== 32'd2) $display("FAIL tt_mis_hold: got %0d want 2", sm_b); else n_pass++;
    // One not-taken from saturated 11 must land on 10, still predicting taken.
    update(6'h10, 1'b0, 1'b1);
    n_checks++; if (pred_b !== 1'b1) $display("FAIL tt_sat_hi: got %b want 1", pred_b); else n_pass++;
    n_checks++; if (sm_b !== 32'd3) $display("FAIL tt_mis3: got %0d want 3", sm_b); else n_pass++;
  endtask

  task automatic test_saturate_low();
    id_pc = 64'h14; id_is_branch = 1'b1;
    for (int i = 0; i < 3; i++) update(6'd5, 1'b0, 1'b0);
    n_checks++; if (pred_b !== 1'b0) $display("FAIL sl_zero: got %b want 0", pred_b); else n_pass++;
    update(6'd5, 1'b1, 1'b0);
    n_checks++; if (pred_b !== 1'b0) $display("FAIL sl_hyst: got %b want 0", pred_b); else n_pass++;
    update(6'd5, 1'b1, 1'b0);
    n_checks++; if (pred_b !== 1'b1) $display("FAIL sl_flip: got %b want 1", pred_b); else n_pass++;
    id_pc = 64'hFFFF_FFFF_FFFF_FF17; #1;
    n_checks++; if (idx_b !== 6'd5) $display("FAIL alias_idx: got %h want 05", idx_b); else n_pass++;
    n_checks++; if (pred_b !== 1'b1) $display("FAIL alias_pred: got %b want 1", pred_b); else n_pass++;
  endtask

  task automatic test_same_cycle();
    do_reset();
    id_pc = 64'h40; id_is_branch = 1'b1;
    ex_pred_index = 6'h10; ex_br_taken = 1'b1; ex_br_pred = 1'b0; ex_update_en = 1'b1;
    #1;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL sc_before: got %b want 0", pred_b); else n_pass++;
    @(posedge clk); #1; ex_update_en = 1'b0; #1;
    n_checks++; if (pred_b !== 1'b1) $display("FAIL sc_after: got %b want 1", pred_b); else n_pass++;
  endtask

  task automatic test_gshare();
    do_reset();
    update(6'h3F, 1'b1, 1'b0);
    n_checks++; if (ghr_g !== 4'h1) $display("FAIL gs_ghr1: got %h want 1", ghr_g); else n_pass++;
    update(6'h3F, 1'b1, 1'b0);
    update(6'h3F, 1'b0, 1'b0);
    update(6'h3F, 1'b1, 1'b0);
    n_checks++; if (ghr_g !== 4'hD) $display("FAIL gs_ghr: got %h want d", ghr_g); else n_pass++;
    ex_br_taken = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (ghr_g !== 4'hD) $display("FAIL gs_idle_ghr: got %h want d", ghr_g); else n_pass++;
    n_checks++; if (sb_g !== 32'd4) $display("FAIL gs_idle_br: got %0d want 4", sb_g); else n_pass++;
    id_pc = 64'h40; id_is_branch = 1'b1; #1;
    n_checks++; if (idx_g !== 6'h1D) $display("FAIL gs_idx: got %h want 1d", idx_g); else n_pass++;
    n_checks++; if (idx_b !== 6'h10) $display("FAIL gs_bim_idx: got %h want 10", idx_b); else n_pass++;
    n_checks++; if (ghr_b !== 1'b0) $display("FAIL gs_bim_ghr: got %b want 0", ghr_b); else n_pass++;
    n_checks++; if (pred_g !== 1'b0) $display("FAIL gs_pred: got %b want 0", pred_g); else n_pass++;
    update(6'h1D, 1'b1, 1'b0);
    n_checks++; if (idx_g !== 6'h1B) $display("FAIL gs_idx2: got %h want 1b", idx_g); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_pc = 64'h40; id_is_branch = 1'b1;
    update(6'h10, 1'b1, 1'b0);
    update(6'h10, 1'b1, 1'b0);
    ex_pred_index = 6'h10; ex_br_taken = 1'b1; ex_br_pred = 1'b0; ex_update_en = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (sb_b !== 32'd0) $display("FAIL rm_br_async: got %0d want 0", sb_b); else n_pass++;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL rm_pred_async: got %b want 0", pred_b); else n_pass++;
    n_checks++; if (ghr_g !== 4'h0) $display("FAIL rm_ghr_async: got %h want 0", ghr_g); else n_pass++;
    @(posedge clk); #1;
    ex_update_en = 1'b0; rst = 1'b0; #1;
    n_checks++;
    if (sb_b !== 32'd0 || sm_b !== 32'd0) $display("FAIL rm_strobe: got %0d/%0d want 0/0", sb_b, sm_b);
    else n_pass++;
    n_checks++; if (pred_b !== 1'b0) $display("FAIL rm_pred: got %b want 0", pred_b); else n_pass++;
    // A single taken update from the reset value 01 must flip the prediction.
    update(6'h10, 1'b1, 1'b1);
    n_checks++; if (pred_b !== 1'b1) $display("FAIL rm_weak: got %b want 1", pred_b); else n_pass++;
    n_checks++; if (sb_b !== 32'd1) $display("FAIL rm_br1: got %0d want 1", sb_b); else n_pass++;
    n_checks++; if (sm_b !== 32'd0) $display("FAIL rm_mis0: got %0d want 0", sm_b); else n_pass++;
  endtask

  task automatic test_wrap();
    force dut_b.stat_branches_d = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    release dut_b.stat_branches_d;
    #1;
    n_checks++;
    if (sb_b !== 32'hFFFF_FFFF) $display("FAIL wrap_preload: got %h want ffffffff", sb_b);
    else n_pass++;
    update(6'h01, 1'b0, 1'b0);
    n_checks++; if (sb_b !== 32'h0) $display("FAIL wrap: got %h want 00000000", sb_b); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_saturate_low();
    test_same_cycle();
    test_gshare();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
